// File: rtl/ddr2_burst_write_control.sv
// ddr2_burst_write_control
// Streams a burst of DATA_W-bit beats into the MIG user interface. A burst
// request (start address + beat count) is latched in IDLE, then the command
// channel (app_en/app_rdy) and write-data channel (app_wdf_wren/app_wdf_rdy)
// run independently, with the data side allowed at most WDF_LEAD beats ahead
// of the command side. A sticky read_enable rises once READ_EN_THRESHOLD
// commands have been committed since reset.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/req_len   burst request handshake
//   data_valid/data_ready/data_in   upstream write beats
//   busy, done, read_enable         status
//   app_rdy, app_en, app_cmd, app_addr                   MIG command channel
//   app_wdf_rdy, app_wdf_wren, app_wdf_end, app_wdf_data MIG write-data channel
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a burst request, req_ready high
// RUN   | moving beats; command and data channels progress separately
// DONE  | burst fully committed, done pulses for one cycle
module ddr2_burst_write_control #(
    parameter int ADDR_W            = 27,
    parameter int DATA_W            = 128,
    parameter int LEN_W             = 8,
    parameter int ADDR_STEP         = 8,
    parameter int WDF_LEAD          = 4,
    parameter int READ_EN_THRESHOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              read_enable,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [DATA_W-1:0] app_wdf_data
);

    localparam int RC_W = $clog2(READ_EN_THRESHOLD + 1);
    localparam logic [RC_W-1:0]   THRESH = RC_W'(READ_EN_THRESHOLD);
    localparam logic [LEN_W:0]    LEAD   = (LEN_W+1)'(WDF_LEAD);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cmd_cnt, wdf_cnt, load_cnt;
    logic [LEN_W-1:0]  cmd_cnt_next, wdf_cnt_next;
    logic [LEN_W-1:0]  lead_cnt;
    logic [RC_W-1:0]   total_cnt, total_cnt_next;
    logic              cmd_acc, wdf_acc, data_acc, req_acc;

    assign cmd_acc  = app_en & app_rdy;
    assign wdf_acc  = app_wdf_wren & app_wdf_rdy;
    assign data_acc = data_valid & data_ready;
    assign req_acc  = req_valid & req_ready;

    assign cmd_cnt_next = cmd_cnt + LEN_W'(cmd_acc);
    assign wdf_cnt_next = wdf_cnt + LEN_W'(wdf_acc);
    assign lead_cnt     = load_cnt - cmd_cnt;

    // A new beat may enter only if the wdf register is free (or draining
    // this cycle) and the data side is not already WDF_LEAD beats ahead.
    assign data_ready = (state == S_RUN) && (load_cnt < len)
                        && ({1'b0, lead_cnt} < LEAD)
                        && (!app_wdf_wren || app_wdf_rdy);

    // A command is only issued once its beat has been presented to the MIG.
    // Every term is registered, so app_en/app_addr hold until app_rdy.
    assign app_en = (state == S_RUN) && (cmd_cnt < len)
                    && (({1'b0, wdf_cnt} + (LEN_W+1)'(app_wdf_wren)) > {1'b0, cmd_cnt});

    assign app_cmd     = app_en ? 3'b000 : 3'b001;
    assign app_addr    = base + ADDR_W'(cmd_cnt) * STEP;
    assign app_wdf_end = app_wdf_wren;

    assign total_cnt_next = (cmd_acc && total_cnt < THRESH) ? total_cnt + 1'b1 : total_cnt;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                req_ready = !reset;
                if (req_valid && !reset)
                    state_next = (req_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cmd_cnt_next == len && wdf_cnt_next == len)
                    state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            base         <= '0;
            len          <= '0;
            cmd_cnt      <= '0;
            wdf_cnt      <= '0;
            load_cnt     <= '0;
            total_cnt    <= '0;
            read_enable  <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
        end else begin
            state     <= state_next;
            total_cnt <= total_cnt_next;
            if (total_cnt_next >= THRESH)
                read_enable <= 1'b1;

            if (req_acc) begin
                base     <= req_addr;
                len      <= req_len;
                cmd_cnt  <= '0;
                wdf_cnt  <= '0;
                load_cnt <= '0;
            end else begin
                cmd_cnt  <= cmd_cnt_next;
                wdf_cnt  <= wdf_cnt_next;
                load_cnt <= load_cnt + LEN_W'(data_acc);
            end

            if (data_acc) begin
                app_wdf_wren <= 1'b1;
                app_wdf_data <= data_in;
            end else if (wdf_acc) begin
                app_wdf_wren <= 1'b0;
            end
        end
    end

endmodule
